// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Multicycle signed multiply / divide unit for the multicycle MIPS datapath.
//   Operands come from REG_A / REG_B; the HI / LO results feed the mfhi / mflo
//   path.  Multiply is iterative shift-add, divide is restoring shift-subtract.
//   Both work on operand magnitudes, one step per clock, and apply the result
//   signs in a final FINISH cycle.
//
//   Ports
//     clk        in   1        rising-edge clock
//     rst        in   1        asynchronous, active-low reset
//     start      in   1        begin operation; sampled only while IDLE
//     op         in   1        0 = mult, 1 = div (two's-complement signed)
//     a_in       in   DATA_W   multiplicand / dividend
//     b_in       in   DATA_W   multiplier / divisor
//     hi_out     out  DATA_W   mult: product upper half; div: remainder
//     lo_out     out  DATA_W   mult: product lower half; div: quotient
//     busy       out  1        high from the edge accepting start until done
//     done       out  1        one-cycle pulse: result valid / op ended
//     div_zero   out  1        sticky: last div had b_in == 0; cleared on start
//     dbg_state  out  2        current FSM state (IDLE=0, RUN=1, FINISH=2)
//
//   Handshake: start is a request that is taken only in IDLE; it is ignored
//   while busy.  done pulses for one cycle in the cycle after the result
//   registers update; a new start may be issued in that same cycle.
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_acc;      // mult: {partial, multiplier}; div: {rem, quo}
    logic [DATA_W-1:0]   r_addend;   // mult: |multiplicand|; div: |divisor|
    logic                r_op;
    logic                r_neg_res;  // sign(a) ^ sign(b)
    logic                r_neg_rem;  // sign of dividend
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_busy;
    logic                r_done;
    logic                r_div_zero;

    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic                w_b_zero;

    logic [DATA_W:0]     w_mul_sum;
    logic [2*DATA_W-1:0] w_mul_next;

    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W-1:0]   w_div_diff;
    logic                w_div_fits;
    logic [2*DATA_W-1:0] w_div_next;

    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;
    logic [DATA_W-1:0]   w_fin_hi;
    logic [DATA_W-1:0]   w_fin_lo;

    // Magnitudes: the most negative value maps onto 2^(DATA_W-1), which is
    // still representable as an unsigned DATA_W-bit number.
    assign w_mag_a  = a_in[DATA_W-1] ? (DATA_W'(0) - a_in) : a_in;
    assign w_mag_b  = b_in[DATA_W-1] ? (DATA_W'(0) - b_in) : b_in;
    assign w_b_zero = (b_in == '0);

    // Multiply step: add multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    // The carry out of the add becomes the new MSB.
    assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, r_addend};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[DATA_W-1:1]}
                                 : {1'b0, r_acc[2*DATA_W-1:1]};

    // Divide step: shift {rem, quo} left by one, trial-subtract the divisor
    // from the widened remainder and shift in the resulting quotient bit.
    assign w_rem_sh   = r_acc[2*DATA_W-1:DATA_W-1];
    assign w_div_fits = (w_rem_sh >= {1'b0, r_addend});
    assign w_div_diff = w_rem_sh[DATA_W-1:0] - r_addend;
    assign w_div_next = w_div_fits ? {w_div_diff, r_acc[DATA_W-2:0], 1'b1}
                                   : {w_rem_sh[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};

    // Sign application.  Quotient truncates toward zero because the divide
    // ran on magnitudes; remainder follows the dividend.
    assign w_prod   = r_neg_res ? ((2*DATA_W)'(0) - r_acc) : r_acc;
    assign w_quo    = r_neg_res ? (DATA_W'(0) - r_acc[DATA_W-1:0]) : r_acc[DATA_W-1:0];
    assign w_rem    = r_neg_rem ? (DATA_W'(0) - r_acc[2*DATA_W-1:DATA_W])
                                : r_acc[2*DATA_W-1:DATA_W];
    assign w_fin_hi = r_op ? w_rem : w_prod[2*DATA_W-1:DATA_W];
    assign w_fin_lo = r_op ? w_quo : w_prod[DATA_W-1:0];

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    // A divide by zero skips the iteration entirely.
                    w_next_state = (op && w_b_zero) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                // The step taken on this edge is the last one.
                if (r_cnt == CNT_W'(DATA_W - 1)) begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_addend   <= '0;
            r_op       <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op       <= op;
                        r_neg_res  <= a_in[DATA_W-1] ^ b_in[DATA_W-1];
                        r_neg_rem  <= a_in[DATA_W-1];
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_div_zero <= op && w_b_zero;
                        if (op) begin
                            r_acc    <= {{DATA_W{1'b0}}, w_mag_a};
                            r_addend <= w_mag_b;
                        end else begin
                            r_acc    <= {{DATA_W{1'b0}}, w_mag_b};
                            r_addend <= w_mag_a;
                        end
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_acc <= r_op ? w_div_next : w_mul_next;
                end
                ST_FINISH: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    // A divide by zero leaves the previous HI/LO in place.
                    if (!r_div_zero) begin
                        r_hi <= w_fin_hi;
                        r_lo <= w_fin_lo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign hi_out    = r_hi;
    assign lo_out    = r_lo;
    assign busy      = r_busy;
    assign done      = r_done;
    assign div_zero  = r_div_zero;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed and randomized checks of mult_div_unit against a reference model
//   built from 64-bit signed arithmetic.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [1:0]  dbg_state;

    int n_vec  = 0;
    int n_miss = 0;

    // Model copy of HI/LO as currently architecturally visible.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    logic [63:0] exp_q[$];

    mult_div_unit #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {hi, lo}. Signed 64-bit arithmetic gives the full product,
    // truncating division and a dividend-signed remainder directly.
    function automatic logic [63:0] ref_model(input logic f_op,
                                              input logic [31:0] f_a,
                                              input logic [31:0] f_b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] res;
        sa = longint'($signed(f_a));
        sb = longint'($signed(f_b));
        if (!f_op) begin
            res = 64'(sa * sb);
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    // ---------------- driver ----------------
    // f_now: drive start right away (used in the done cycle) instead of
    // waiting for the next negedge.  f_poke: pulse start mid-operation.
    task automatic do_op(input logic f_op, input logic [31:0] f_a, input logic [31:0] f_b,
                         input bit f_now, input bit f_poke);
        int          n;
        bit          dz;
        logic [63:0] exp;
        if (!f_now) @(negedge clk);
        start = 1'b1;
        op    = f_op;
        a_in  = f_a;
        b_in  = f_b;
        dz    = f_op && (f_b == 32'd0);
        if (dz) exp_q.push_back({m_hi, m_lo});
        else    exp_q.push_back(ref_model(f_op, f_a, f_b));

        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 1;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("div_zero_after_start", 64'(div_zero), 64'(dz));

        while (!done && n < 60) begin
            chk("hi_hold", 64'(hi_out), 64'(m_hi));
            chk("lo_hold", 64'(lo_out), 64'(m_lo));
            chk("busy_run", 64'(busy), 64'd1);
            a_in  = $urandom;
            b_in  = $urandom;
            op    = 1'($urandom_range(0, 1));
            start = f_poke && (n == 5);
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;

        chk("latency", 64'(n), dz ? 64'd2 : 64'd34);
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        chk("div_zero_end", 64'(div_zero), 64'(dz));
        exp  = exp_q.pop_front();
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        chk("hi_result", 64'(hi_out), 64'(m_hi));
        chk("lo_result", 64'(lo_out), 64'(m_lo));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic [31:0] specials [4];

        rst   = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a_in  = '0;
        b_in  = '0;
        specials[0] = 32'h8000_0000;
        specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h0000_0000;
        specials[3] = 32'h7FFF_FFFF;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // mult 7 * -3
        do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
        chk("mul7x-3_hi", 64'(hi_out), 64'hFFFF_FFFF);
        chk("mul7x-3_lo", 64'(lo_out), 64'hFFFF_FFEB);

        // mult most-negative squared, with start pulsed mid-run
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        chk("mulmin_hi", 64'(hi_out), 64'h4000_0000);
        chk("mulmin_lo", 64'(lo_out), 64'h0000_0000);

        // div -7 / 2
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div-7/2_lo", 64'(lo_out), 64'hFFFF_FFFD);
        chk("div-7/2_hi", 64'(hi_out), 64'hFFFF_FFFF);

        // div by zero keeps previous results
        do_op(1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
        chk("divzero_lo", 64'(lo_out), 64'hFFFF_FFFD);

        // overflow divide, then a mult issued in the done cycle
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("divovf_lo", 64'(lo_out), 64'h8000_0000);
        chk("divovf_hi", 64'(hi_out), 64'h0000_0000);
        do_op(1'b0, 32'd2, 32'd3, 1'b1, 1'b0);
        chk("b2b_lo", 64'(lo_out), 64'd6);
        chk("b2b_hi", 64'(hi_out), 64'd0);

        // reset in the middle of a run
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a_in  = 32'd1234;
        b_in  = 32'd5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_hi", 64'(hi_out), 64'd0);
        chk("midrst_lo", 64'(lo_out), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_no_done", 64'(done), 64'd0);
        end
        @(negedge clk);
        rst  = 1'b1;
        m_hi = '0;
        m_lo = '0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) chk("stray_done_after_rst", 64'(done), 64'd0);
        end
        chk("post_rst_busy", 64'(busy), 64'd0);
        do_op(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0, 1'b0);

        // randomized operations
        for (int i = 0; i < 24; i++) begin
            r_op = 1'($urandom_range(0, 1));
            r_a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            case ($urandom_range(0, 5))
                0:       r_b = 32'd0;
                1:       r_b = specials[$urandom_range(0, 3)];
                2:       r_b = 32'($signed($urandom_range(0, 30)) - 15);
                default: r_b = $urandom;
            endcase
            do_op(r_op, r_a, r_b, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin
        #500000;
        n_miss++;
        $display("FAIL timeout: observed no finish, expected finish before limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "time limit reached");
    end

endmodule
